// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, write-record type and address helper for fb_scanout.
package fb_pkg;
  localparam int FB_ADDR_W = 12;
  localparam int FB_DATA_W = 8;
  localparam int FB_COLS   = 32;
  localparam int FB_ROWS   = 128;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } fb_wr_t;

  function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [6:0] row, input logic [4:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/fb_scanout_if.sv
// Write-stream bus from the voxel engine into fb_scanout.
// Handshake: no ready; a we=1 cycle is accepted unless fifo_full with no same-cycle drain, in which case it is dropped and overflow latches.
interface fb_scanout_if;
  logic        we;
  logic [11:0] addr;
  logic [7:0]  ram_d;
  logic        fifo_full;
  logic        overflow;

  modport master (output we, addr, ram_d, input fifo_full, overflow);
  modport slave  (input we, addr, ram_d, output fifo_full, overflow);
endinterface

// File: rtl/fb_write_fifo.sv
// Write queue between the voxel engine and the framebuffer RAM port.
// A push while full is still accepted when a pop happens in the same cycle; otherwise it is dropped.
module fb_write_fifo
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  fb_wr_t din,
  output fb_wr_t dout,
  output logic   empty,
  output logic   full,
  output logic   overflow
);
  localparam int PW = $clog2(FIFO_DEPTH);

  fb_wr_t        r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          r_overflow;
  logic          w_pop;
  logic          w_push;

  assign empty    = (r_count == '0);
  assign full     = (r_count == (PW+1)'(FIFO_DEPTH));
  assign dout     = r_mem[r_rd_ptr];
  assign overflow = r_overflow;
  assign w_pop    = pop && !empty;
  assign w_push   = push && (!full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (push && !w_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end
endmodule

// File: rtl/fb_scanout.sv
// Framebuffer RAM owner: queues engine writes and scans 256x128 1-bpp video out in step with hpos/vpos.
// Optional whole-buffer clear is enabled by defining FB_CLEAR_EN.
module fb_scanout
  import fb_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         H_TOTAL    = 309,
  parameter int         V_TOTAL    = 262,
  parameter logic [2:0] FG_COLOR   = 3'b111
) (
  input  logic         clk,
  input  logic         reset,
  fb_scanout_if.slave  wr_bus,
  input  logic         display_on,
  input  logic [8:0]   hpos,
  input  logic [8:0]   vpos,
  output logic [2:0]   rgb,
  input  logic         clear_req,
  output logic         clear_busy
);
  localparam logic [8:0] H_PREFETCH = 9'(H_TOTAL - 2);
  localparam logic [8:0] H_LAST     = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST     = 9'(V_TOTAL - 1);
  localparam logic [8:0] COL_LIMIT  = 9'((FB_COLS - 1) * 8);

  logic [FB_DATA_W-1:0] r_ram [FB_COLS*FB_ROWS];
  logic [FB_DATA_W-1:0] r_rd_data;
  logic [FB_DATA_W-1:0] r_shift;
  logic [2:0]           r_rgb;

  logic                 w_fetch_col, w_fetch_c0, w_fetch, w_load, w_pix;
  logic [6:0]           w_next_row;
  logic [FB_ADDR_W-1:0] w_rd_addr;
  fb_wr_t               w_head;
  logic                 w_empty, w_full, w_overflow, w_pop;
  logic                 w_clr_busy, w_clr_wr;
  logic [FB_ADDR_W-1:0] w_clr_addr;
  logic                 w_ram_we;
  logic [FB_ADDR_W-1:0] w_wr_addr;
  logic [FB_DATA_W-1:0] w_wr_data;

  // Scanout owns the port one cycle ahead of each 8-pixel group, and at H_TOTAL-2 for the next line's first byte.
  assign w_fetch_col = (hpos[2:0] == 3'd6) && (hpos < COL_LIMIT);
  assign w_fetch_c0  = (hpos == H_PREFETCH);
  assign w_fetch     = w_fetch_col || w_fetch_c0;
  assign w_load      = ((hpos[2:0] == 3'd7) && (hpos < COL_LIMIT)) || (hpos == H_LAST);
  assign w_next_row  = (vpos == V_LAST) ? 7'd0 : (vpos[6:0] + 7'd1);
  assign w_rd_addr   = w_fetch_c0 ? fb_addr(w_next_row, 5'd0)
                                  : fb_addr(vpos[6:0], hpos[7:3] + 5'd1);

  fb_write_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_bus.we),
    .pop      (w_pop),
    .din      ({wr_bus.addr, wr_bus.ram_d}),
    .dout     (w_head),
    .empty    (w_empty),
    .full     (w_full),
    .overflow (w_overflow)
  );

  assign wr_bus.fifo_full = w_full;
  assign wr_bus.overflow  = w_overflow;

`ifdef FB_CLEAR_EN
  logic                 r_clr_busy;
  logic [FB_ADDR_W-1:0] r_clr_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_clr_busy <= 1'b0;
      r_clr_addr <= '0;
    end else if (!r_clr_busy) begin
      r_clr_addr <= '0;
      if (clear_req) r_clr_busy <= 1'b1;
    end else if (!w_fetch) begin
      r_clr_addr <= r_clr_addr + 12'd1;
      if (r_clr_addr == 12'hFFF) r_clr_busy <= 1'b0;
    end
  end

  assign w_clr_busy = r_clr_busy;
  assign w_clr_addr = r_clr_addr;
`else
  logic w_unused_clear_req;
  assign w_unused_clear_req = clear_req;
  assign w_clr_busy         = 1'b0;
  assign w_clr_addr         = '0;
`endif

  // The clear takes every free slot until done, so the queue holds its writes until afterwards.
  assign w_clr_wr   = w_clr_busy && !w_fetch;
  assign w_pop      = !w_fetch && !w_empty && !w_clr_busy;
  assign w_ram_we   = w_clr_wr || w_pop;
  assign w_wr_addr  = w_clr_wr ? w_clr_addr : w_head.addr;
  assign w_wr_data  = w_clr_wr ? 8'h00 : w_head.data;
  assign clear_busy = w_clr_busy;

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_wr_addr] <= w_wr_data;
    if (w_fetch)  r_rd_data <= r_ram[w_rd_addr];
  end

  assign w_pix = r_shift[7] && (vpos[8:7] == 2'b00) && !hpos[8];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_rgb   <= 3'b000;
    end else begin
      r_shift <= w_load ? r_rd_data : {r_shift[6:0], 1'b0};
      r_rgb   <= (display_on && w_pix) ? FG_COLOR : 3'b000;
    end
  end

  assign rgb = r_rgb;
endmodule
